fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS datapath, directly upstream of the decode control unit. It owns the PC register, drives the instruction-cache request (iREN/imemaddr), waits on ihit, and fills the IF/ID latch whose `instr` word the decoder consumes. It also handles hazard stalls, branch/jump redirects with miss draining, and halt shutdown.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- ihit  in  1  icache returns `imemload` for `imemaddr` this cycle.
- imemload  in  32  instruction word from icache.
- stall  in  1  hazard unit: hold PC and IF/ID latch.
- redirect  in  1  EX resolved a taken branch, jump, or JR; flush and refetch.
- redirect_pc  in  32  target for `redirect`; word-aligned.
- halt  in  1  decode sees HALT in IF/ID; stop fetching.
- iREN  out  1  icache read request.
- imemaddr  out  32  icache address.
- instr  out  32  IF/ID instruction to decode.
- pc_plus4  out  32  IF/ID PC+4 of `instr`, for branch and JAL.
- valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- fetch_halted  out  1  stage is in HALTED.

## Operation
- States:
  - RUN: normal fetching.
  - DRAIN: redirect arrived during an outstanding miss.
  - HALTED: fetching stopped.
- Registers: `pc`, `target` (32), `state`, IF/ID {instr, pc_plus4, valid}.
- `imemaddr = pc` in every state. `iREN = 1` in RUN and DRAIN, `0` in HALTED.
- Protocol rule: while iREN=1 and ihit=0, `imemaddr` must not change. A redirect during a miss is therefore deferred via DRAIN.
- Per-edge priority: nRST=0 > redirect > halt > stall > ihit.
- Reset (nRST=0 at an edge):
  - pc=PC_INIT, target=0, state=RUN.
  - instr=0, pc_plus4=0, valid=0.
  - Resulting outputs: iREN=1, imemaddr=PC_INIT, fetch_halted=0.
- "Flush" means IF/ID is set to {0, 0, 0}. "Bubble" means the same load.
- RUN:
  - redirect & ihit: pc<=redirect_pc; flush.
  - redirect & !ihit: target<=redirect_pc; state<=DRAIN; flush.
  - halt (no redirect): state<=HALTED; pc held. IF/ID holds if stall, else bubble.
  - stall: pc and IF/ID held, even if ihit. The word is refetched later.
  - ihit: pc<=pc+4; IF/ID<={imemload, pc+4, 1}.
  - otherwise (miss): pc held; bubble.
- DRAIN:
  - redirect: target<=redirect_pc (latest wins); flush.
  - ihit: pc<=target (or the new redirect_pc if redirect is also high); state<=RUN; returned word discarded.
  - IF/ID stays flushed in DRAIN regardless of stall.
- HALTED:
  - redirect: pc<=redirect_pc; state<=RUN; flush. This covers a HALT on a squashed path.
  - otherwise: pc held. IF/ID holds if stall, else bubble.
- Arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- A halt asserted during a miss abandons the request by dropping iREN. The icache tolerates this.

## Timing
- `iREN` and `imemaddr` come from registers only. There is no combinational path from any input to any output.
- Fetch latency: with ihit asserted in cycle N, `instr` and `valid` show the word in cycle N+1.
- Back-to-back hits: one instruction per cycle.
- Redirect seen at edge N:
  - Hit case: `imemaddr=redirect_pc` in cycle N+1; `valid=0` in N+1.
  - Miss case: `imemaddr` stays the old pc until the ihit edge, then becomes target on the following cycle.
- `fetch_halted` rises the cycle after the edge sampling halt. `iREN` falls in that same cycle.

## Test plan
- Reset with PC_INIT=0, ihit=1, imemload=32'h3401_0005 (ori): by cycle 2, imemaddr=4, instr=32'h3401_0005, pc_plus4=4, valid=1. Every output equals its reset value while nRST=0.
- Miss then hit at pc=8, ihit low for 3 cycles: imemaddr stays 8 and valid=0 for 3 cycles. After ihit, instr loads and imemaddr=12.
- Stall with ihit=1 at pc=16 for 2 cycles: pc=16 and IF/ID unchanged for both cycles. After stall drops, normal advance resumes.
- Redirect to 32'h40 during a miss at pc=20: state=DRAIN, imemaddr stays 20 until ihit, valid=0 throughout, the returned word is discarded. Next cycle imemaddr=32'h40.
- Halt while stall=0: next cycle fetch_halted=1, iREN=0, valid=0, pc frozen. A later redirect to 32'h80 restores RUN with imemaddr=32'h80.
- Simultaneous redirect, halt, and stall with ihit=1 at pc=24: redirect wins. pc=redirect_pc, IF/ID flushed, state stays RUN.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PC, drives icache request,
// fills IF/ID; handles stall, redirect (with miss drain), halt.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    instr: 32'h0, pc_plus4: 32'h0, valid: 1'b0
  };

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] target, target_n;
  if_id_t      ifid, ifid_n;
  logic [31:0] pc_inc;

  assign pc_inc = pc + 32'd4;

  // state, pc, target and IF/ID latch
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= RUN;
      pc     <= PC_INIT;
      target <= 32'h0;
      ifid   <= BUBBLE;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      target <= target_n;
      ifid   <= ifid_n;
    end
  end

  // next-state: redirect > halt > stall > ihit
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    target_n = target;
    ifid_n   = ifid;
    unique case (state)
      RUN: begin
        if (redirect) begin
          ifid_n = BUBBLE;
          if (ihit) begin
            pc_n = redirect_pc;
          end else begin
            target_n = redirect_pc;
            state_n  = DRAIN;
          end
        end else if (halt) begin
          state_n = HALTED;
          if (!stall) ifid_n = BUBBLE;
        end else if (stall) begin
          ifid_n = ifid;
        end else if (ihit) begin
          pc_n   = pc_inc;
          ifid_n = '{
            instr: imemload, pc_plus4: pc_inc, valid: 1'b1
          };
        end else begin
          ifid_n = BUBBLE;
        end
      end
      DRAIN: begin
        ifid_n = BUBBLE;
        if (redirect) target_n = redirect_pc;
        if (ihit) begin
          pc_n    = redirect ? redirect_pc : target;
          state_n = RUN;
        end
      end
      HALTED: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = RUN;
          ifid_n  = BUBBLE;
        end else if (!stall) begin
          ifid_n = BUBBLE;
        end
      end
      default: begin
        state_n = RUN;
        ifid_n  = BUBBLE;
      end
    endcase
  end

  assign imemaddr     = pc;
  assign iREN         = (state != HALTED);
  assign fetch_halted = (state == HALTED);
  assign instr        = ifid.instr;
  assign pc_plus4     = ifid.pc_plus4;
  assign valid        = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected outputs queued
// per driven cycle, popped and compared after each edge.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST, ihit, stall, redirect, halt;
  logic [31:0] imemload, redirect_pc;
  logic        iREN, valid, fetch_halted;
  logic [31:0] imemaddr, instr, pc_plus4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        iren;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        vld;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  fetch_stage #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit),
    .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .iREN(iREN), .imemaddr(imemaddr),
    .instr(instr), .pc_plus4(pc_plus4), .valid(valid),
    .fetch_halted(fetch_halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(
    input string tag,
    input logic r, input logic h, input logic [31:0] ld,
    input logic s, input logic rd, input logic [31:0] rpc,
    input logic hl,
    input logic [31:0] ea, input logic er,
    input logic [31:0] ei, input logic [31:0] ep,
    input logic ev, input logic eh);
    exp_t e;
    nRST = r; ihit = h; imemload = ld; stall = s;
    redirect = rd; redirect_pc = rpc; halt = hl;
    e.tag = tag; e.addr = ea; e.iren = er; e.ins = ei;
    e.pc4 = ep; e.vld = ev; e.hlt = eh;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".addr"}, imemaddr, e.addr);
    chk({e.tag, ".iren"}, {31'h0, iREN}, {31'h0, e.iren});
    chk({e.tag, ".instr"}, instr, e.ins);
    chk({e.tag, ".pc4"}, pc_plus4, e.pc4);
    chk({e.tag, ".valid"}, {31'h0, valid}, {31'h0, e.vld});
    chk({e.tag, ".halted"}, {31'h0, fetch_halted},
        {31'h0, e.hlt});
  endtask

  localparam logic [31:0] ORI = 32'h3401_0005;

  initial begin
    // reset, ihit high the whole time
    cyc("rst0", 0,1,ORI, 0,0,0,0, 0,1,0,0,0,0);
    cyc("rst1", 0,1,ORI, 0,0,0,0, 0,1,0,0,0,0);
    // first fetches
    cyc("hit0", 1,1,ORI, 0,0,0,0, 4,1,ORI,4,1,0);
    cyc("hit4", 1,1,32'hA0A0_0004, 0,0,0,0,
        8,1,32'hA0A0_0004,8,1,0);
    // miss at pc=8 for 3 cycles
    for (int i = 0; i < 3; i++)
      cyc("miss8", 1,0,32'hDEAD_BEEF, 0,0,0,0, 8,1,0,0,0,0);
    cyc("hit8", 1,1,32'hB0B0_0008, 0,0,0,0,
        12,1,32'hB0B0_0008,12,1,0);
    cyc("hit12", 1,1,32'hC0C0_000C, 0,0,0,0,
        16,1,32'hC0C0_000C,16,1,0);
    // stall at pc=16 with ihit
    for (int i = 0; i < 2; i++)
      cyc("stall16", 1,1,32'h1111_1111, 1,0,0,0,
          16,1,32'hC0C0_000C,16,1,0);
    cyc("hit16", 1,1,32'hD0D0_0010, 0,0,0,0,
        20,1,32'hD0D0_0010,20,1,0);
    // redirect during miss at pc=20 -> DRAIN
    cyc("rdmiss", 1,0,0, 0,1,32'h40,0, 20,1,0,0,0,0);
    cyc("drain", 1,0,0, 1,0,0,0, 20,1,0,0,0,0);
    cyc("drainhit", 1,1,32'hBAD0_BAD0, 0,0,0,0,
        32'h40,1,0,0,0,0);
    cyc("hit40", 1,1,32'hE0E0_0040, 0,0,0,0,
        32'h44,1,32'hE0E0_0040,32'h44,1,0);
    // halt without stall
    cyc("halt", 1,1,32'h2222_2222, 0,0,0,1,
        32'h44,0,0,0,0,1);
    cyc("halted", 1,1,32'h2222_2222, 0,0,0,0,
        32'h44,0,0,0,0,1);
    cyc("unhalt", 1,0,0, 0,1,32'h80,0, 32'h80,1,0,0,0,0);
    cyc("hit80", 1,1,32'hF0F0_0080, 0,0,0,0,
        32'h84,1,32'hF0F0_0080,32'h84,1,0);
    // go to pc=24, then redirect+halt+stall together
    cyc("rdhit", 1,1,32'h3333_3333, 0,1,24,0, 24,1,0,0,0,0);
    cyc("rdall", 1,1,32'h4444_4444, 1,1,32'h100,1,
        32'h100,1,0,0,0,0);
    cyc("hit100", 1,1,32'h5555_0100, 0,0,0,0,
        32'h104,1,32'h5555_0100,32'h104,1,0);
    // pc wrap at top of address space
    cyc("rdtop", 1,1,0, 0,1,32'hFFFF_FFFC,0,
        32'hFFFF_FFFC,1,0,0,0,0);
    cyc("wrap", 1,1,32'h6666_6666, 0,0,0,0,
        0,1,32'h6666_6666,0,1,0);
    // halt while stalled keeps IF/ID, then bubble
    cyc("hit0b", 1,1,32'h7777_0000, 0,0,0,0,
        4,1,32'h7777_0000,4,1,0);
    cyc("haltst", 1,1,0, 1,0,0,1, 4,0,32'h7777_0000,4,1,1);
    cyc("haltbub", 1,0,0, 0,0,0,0, 4,0,0,0,0,1);
    // DRAIN with a second redirect arriving on ihit
    cyc("unhalt2", 1,0,0, 0,1,32'h200,0, 32'h200,1,0,0,0,0);
    cyc("rdmiss2", 1,0,0, 0,1,32'h300,0, 32'h200,1,0,0,0,0);
    cyc("drainrd", 1,1,32'h8888_8888, 0,1,32'h400,0,
        32'h400,1,0,0,0,0);
    cyc("hit400", 1,1,32'h9999_0400, 0,0,0,0,
        32'h404,1,32'h9999_0400,32'h404,1,0);
    // reset mid-run
    cyc("rst2", 0,1,0, 0,1,32'h500,1, 0,1,0,0,0,0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
